// File: rtl/fsm_seq_pkg.sv
// Shared phase encodings and display codes for the step sequencer.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_COUNT = 2'd1,
    PH_WAIT  = 2'd2,
    PH_DONE  = 2'd3
  } phase_e;

  localparam logic [7:0] LED_IDLE  = 8'd0;
  localparam logic [7:0] LED_COUNT = 8'd10;
  localparam logic [7:0] LED_WAIT  = 8'd5;
  localparam logic [7:0] LED_DONE  = 8'd15;

  function automatic logic [7:0] led_of(phase_e p);
    logic [7:0] code;
    case (p)
      PH_COUNT: code = LED_COUNT;
      PH_WAIT:  code = LED_WAIT;
      PH_DONE:  code = LED_DONE;
      default:  code = LED_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a slow asynchronous level, with rise/fall pulses
// taken from the synchronized value against a one-cycle delayed copy.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~dly_q;
  assign fall_o  = ~sync_q & dly_q;

endmodule

// File: rtl/fsm_step_sequencer.sv
// Four-phase display sequencer: prescaler tick / step button arbitration,
// req/ack advance handshake and per-phase LED code.
// phase | IDLE: wait for go rise | COUNT: spend COUNT_STEPS advances | WAIT, DONE: one advance each
module fsm_step_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int unsigned MAX_COUNT   = 10_000_000,
  parameter int unsigned COUNT_STEPS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       step,
  input  logic       auto_mode,
  input  logic       adv_ack,
  output logic       adv_req,
  output logic [1:0] phase,
  output logic [7:0] led_code,
  output logic       busy,
  output logic       missed
);

  localparam int SW = $clog2(COUNT_STEPS + 1);
  localparam logic [23:0]   PRE_LAST   = 24'(MAX_COUNT - 1);
  localparam logic [SW-1:0] STEPS_LAST = SW'(COUNT_STEPS);

  logic go_lvl, go_rise, go_fall;
  logic step_lvl, step_rise, step_fall;
  logic unused_sync;

  sync_edge u_sync_go (
    .clk(clk), .rst_n(rst_n), .d_i(go),
    .level_o(go_lvl), .rise_o(go_rise), .fall_o(go_fall)
  );

  sync_edge u_sync_step (
    .clk(clk), .rst_n(rst_n), .d_i(step),
    .level_o(step_lvl), .rise_o(step_rise), .fall_o(step_fall)
  );

  assign unused_sync = go_fall ^ step_lvl ^ step_fall;

  phase_e        phase_q, phase_d;
  logic [23:0]   pre_q, pre_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d, step_inc;
  logic          req_q, req_d;
  logic          missed_q, missed_d;
  logic [7:0]    led_q;
  logic          busy_q;
  logic [1:0]    prime_q;
  logic          armed_q;

  logic tick, ev, abort, accept, go_start, idle_entry;

  // A go level held high through reset must not look like a rise: only start
  // once the synchronizer has delivered a genuine low sample.
  assign go_start = go_rise & armed_q;

  assign tick     = (phase_q != PH_IDLE) && (pre_q == PRE_LAST);
  assign ev       = (auto_mode & tick) | step_rise;
  assign abort    = (phase_q != PH_IDLE) & ~go_lvl;
  assign accept   = ev & ~req_q & (phase_q != PH_IDLE) & ~abort;
  assign step_inc = step_cnt_q + SW'(1);

  always_comb begin
    phase_d    = phase_q;
    step_cnt_d = step_cnt_q;
    req_d      = req_q & ~adv_ack;
    if (abort) begin
      phase_d = PH_IDLE;
      req_d   = 1'b0;
    end else if (accept) begin
      req_d = 1'b1;
      case (phase_q)
        PH_COUNT: begin
          step_cnt_d = step_inc;
          if (step_inc == STEPS_LAST) phase_d = PH_WAIT;
        end
        PH_WAIT: phase_d = PH_DONE;
        PH_DONE: phase_d = PH_IDLE;
        default: phase_d = PH_IDLE;
      endcase
    end else if ((phase_q == PH_IDLE) && go_start) begin
      phase_d    = PH_COUNT;
      step_cnt_d = '0;
    end
  end

  assign idle_entry = (phase_q != PH_IDLE) && (phase_d == PH_IDLE);

  always_comb begin
    missed_d = (missed_q | (ev & req_q)) & ~idle_entry;
    if ((phase_q == PH_IDLE) || (phase_d == PH_IDLE) || tick) pre_d = '0;
    else pre_d = pre_q + 24'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_IDLE;
      pre_q      <= '0;
      step_cnt_q <= '0;
      req_q      <= 1'b0;
      missed_q   <= 1'b0;
      led_q      <= LED_IDLE;
      busy_q     <= 1'b0;
      prime_q    <= '0;
      armed_q    <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      pre_q      <= pre_d;
      step_cnt_q <= step_cnt_d;
      req_q      <= req_d;
      missed_q   <= missed_d;
      led_q      <= led_of(phase_d);
      busy_q     <= (phase_d != PH_IDLE);
      prime_q    <= {prime_q[0], 1'b1};
      armed_q    <= armed_q | (prime_q[1] & ~go_lvl);
    end
  end

  assign adv_req  = req_q;
  assign phase    = phase_q;
  assign led_code = led_q;
  assign busy     = busy_q;
  assign missed   = missed_q;

endmodule
